// File: rtl/requant_output_writer_if.sv
// Activation-RAM write port of the requant output writer: one valid/ready word write.
interface requant_output_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int SA_N       = 4
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [SA_N*8-1:0]     mem_wdata;
  logic                  mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/requant_output_writer.sv
// Reassembles per-lane int8 requant results into one word per pixel and writes them to RAM.
// Optional REQ_WRITER_PERF_EN adds stall_cycles / max_slots_used statistics.
module requant_output_writer #(
  parameter int SA_N       = 4,
  parameter int MAX_N      = 16,
  parameter int N_BITS     = $clog2(MAX_N),
  parameter int NUM_SLOTS  = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH-1:0]         row_stride,
  input  logic [2*N_BITS:0]             num_pixels,
  input  logic [SA_N-1:0]               in_valid,
  input  logic [SA_N-1:0][N_BITS-1:0]   in_row,
  input  logic [SA_N-1:0][N_BITS-1:0]   in_col,
  input  logic [SA_N-1:0][7:0]          in_data,
  requant_output_writer_if.master       mem,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
`ifdef REQ_WRITER_PERF_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [$clog2(NUM_SLOTS+1)-1:0] max_slots_used
`endif
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = 2*N_BITS + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_DONE = 2'd2} state_t;

  state_t                           state_r, state_s;
  logic [ADDR_WIDTH-1:0]            base_r, stride_r;
  logic [CNT_W-1:0]                 num_pix_r, wr_cnt_r;
  logic                             busy_r, done_r, overflow_r;
  logic                             mem_we_r;
  logic [ADDR_WIDTH-1:0]            mem_addr_r;
  logic [SA_N*8-1:0]                mem_wdata_r;

  logic [NUM_SLOTS-1:0]             slot_valid_r, slot_valid_s;
  logic [NUM_SLOTS-1:0][N_BITS-1:0] slot_row_r, slot_row_s, slot_col_r, slot_col_s;
  logic [NUM_SLOTS-1:0][SA_N-1:0]   slot_mask_r, slot_mask_s;
  logic [NUM_SLOTS-1:0][SA_N*8-1:0] slot_data_r, slot_data_s;

  logic                             accept_s, tile_start_s, xfer_en_s, drop_s;
  logic [NUM_SLOTS-1:0]             complete_s, freed_s;
  logic [IDX_W-1:0]                 xfer_idx_s;
  logic [ADDR_WIDTH-1:0]            xfer_addr_s;

  assign accept_s     = mem_we_r && mem.mem_ready;
  assign tile_start_s = (state_r == ST_IDLE) && start;

  // Lowest complete slot moves to the output register when it is empty or draining.
  always_comb begin
    complete_s = '0;
    xfer_idx_s = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      complete_s[i] = slot_valid_r[i] && (&slot_mask_r[i]);
      xfer_idx_s    = complete_s[i] ? IDX_W'(i) : xfer_idx_s;
    end
    xfer_en_s   = (|complete_s) && (!mem_we_r || accept_s);
    xfer_addr_s = base_r + ADDR_WIDTH'(slot_row_r[xfer_idx_s]) * stride_r
                + ADDR_WIDTH'(slot_col_r[xfer_idx_s]);
  end

  // Lane capture; a slot freed this edge is neither matched nor reallocated.
  always_comb begin : capture_comb
    logic             lane_en, hit, avail_any, match, avail;
    logic [IDX_W-1:0] hit_idx, free_idx;
    lane_en      = 1'b0;
    hit          = 1'b0;
    avail_any    = 1'b0;
    match        = 1'b0;
    avail        = 1'b0;
    hit_idx      = '0;
    free_idx     = '0;
    drop_s       = 1'b0;
    freed_s      = '0;
    slot_valid_s = slot_valid_r;
    slot_row_s   = slot_row_r;
    slot_col_s   = slot_col_r;
    slot_mask_s  = slot_mask_r;
    slot_data_s  = slot_data_r;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      freed_s[j]      = xfer_en_s && (xfer_idx_s == IDX_W'(j));
      slot_valid_s[j] = slot_valid_r[j] && !freed_s[j];
    end
    for (int k = 0; k < SA_N; k++) begin
      lane_en   = (state_r == ST_ACTIVE) && in_valid[k];
      hit       = 1'b0;
      avail_any = 1'b0;
      hit_idx   = '0;
      free_idx  = '0;
      for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
        match     = slot_valid_s[j] && (slot_row_s[j] == in_row[k]) && (slot_col_s[j] == in_col[k]);
        avail     = !slot_valid_s[j] && !freed_s[j];
        hit       = hit || match;
        hit_idx   = match ? IDX_W'(j) : hit_idx;
        avail_any = avail_any || avail;
        free_idx  = avail ? IDX_W'(j) : free_idx;
      end
      if (lane_en && hit) begin
        slot_mask_s[hit_idx][k]        = 1'b1;
        slot_data_s[hit_idx][8*k +: 8] = in_data[k];
      end else if (lane_en && avail_any) begin
        slot_valid_s[free_idx]          = 1'b1;
        slot_row_s[free_idx]            = in_row[k];
        slot_col_s[free_idx]            = in_col[k];
        slot_mask_s[free_idx]           = SA_N'(1'b1) << k;
        slot_data_s[free_idx][8*k +: 8] = in_data[k];
      end else begin
        drop_s = drop_s || lane_en;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = start ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: state_s = ((wr_cnt_r == num_pix_r) && !mem_we_r) ? ST_DONE : ST_ACTIVE;
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Slot storage, output register, tile parameters and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_r <= '0;
      slot_row_r   <= '0;
      slot_col_r   <= '0;
      slot_mask_r  <= '0;
      slot_data_r  <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      base_r       <= '0;
      stride_r     <= '0;
      num_pix_r    <= '0;
      wr_cnt_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      slot_valid_r <= slot_valid_s;
      slot_row_r   <= slot_row_s;
      slot_col_r   <= slot_col_s;
      slot_mask_r  <= slot_mask_s;
      slot_data_r  <= slot_data_s;
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      if (xfer_en_s) begin
        mem_we_r    <= 1'b1;
        mem_addr_r  <= xfer_addr_s;
        mem_wdata_r <= slot_data_r[xfer_idx_s];
      end else if (accept_s) begin
        mem_we_r <= 1'b0;
      end
      if (tile_start_s) begin
        base_r     <= base_addr;
        stride_r   <= row_stride;
        num_pix_r  <= num_pixels;
        wr_cnt_r   <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (accept_s) wr_cnt_r   <= wr_cnt_r + CNT_W'(1'b1);
        if (drop_s)   overflow_r <= 1'b1;
      end
    end
  end

  assign mem.mem_we    = mem_we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign overflow      = overflow_r;

`ifdef REQ_WRITER_PERF_EN
  localparam int USED_W = $clog2(NUM_SLOTS + 1);
  logic [31:0]       stall_r;
  logic [USED_W-1:0] max_used_r, used_s;

  assign used_s = USED_W'($countones(slot_valid_r));

  // Per-tile stall count and slot high-water mark, frozen outside ACTIVE.
  always_ff @(posedge clk) begin
    if (reset || tile_start_s) begin
      stall_r    <= 32'd0;
      max_used_r <= '0;
    end else if (state_r == ST_ACTIVE) begin
      if (mem_we_r && !mem.mem_ready) stall_r <= stall_r + 32'd1;
      if (used_s > max_used_r)        max_used_r <= used_s;
    end
  end

  assign stall_cycles   = stall_r;
  assign max_slots_used = max_used_r;
`endif
endmodule

// File: tb/tb_requant_output_writer.sv
// Scoreboard bench for requant_output_writer: expected writes queued at stimulus time,
// popped and compared whenever the RAM port accepts a word.
module tb_requant_output_writer;
  logic              clk = 1'b0;
  logic              reset, start;
  logic [15:0]       base_addr, row_stride;
  logic [8:0]        num_pixels;
  logic [3:0]        in_valid;
  logic [3:0][3:0]   in_row, in_col;
  logic [3:0][7:0]   in_data;
  logic              busy, done, overflow;
`ifdef REQ_WRITER_PERF_EN
  logic [31:0]       stall_cycles;
  logic [2:0]        max_slots_used;
`endif

  requant_output_writer_if #(.ADDR_WIDTH(16), .SA_N(4)) mem_if ();

  requant_output_writer dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .row_stride(row_stride), .num_pixels(num_pixels),
    .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
    .mem(mem_if), .busy(busy), .done(done), .overflow(overflow)
`ifdef REQ_WRITER_PERF_EN
    , .stall_cycles(stall_cycles), .max_slots_used(max_slots_used)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input logic [15:0] b, input logic [15:0] s,
                                           input logic [3:0] r, input logic [3:0] c);
    return b + 16'(r) * s + 16'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [15:0] b, input logic [15:0] s, input logic [8:0] n);
    base_addr  = b;
    row_stride = s;
    num_pixels = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // All valid lanes carry the same pixel tag; lane k takes byte k of d.
  task automatic put_lanes(input logic [3:0] v, input logic [3:0] r, input logic [3:0] c,
                           input logic [31:0] d);
    in_valid = v;
    for (int k = 0; k < 4; k++) begin
      in_row[k] = r;
      in_col[k] = c;
    end
    in_data  = d;
    tick();
    in_valid = 4'd0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = done;
    end
    check(tag, 64'(seen), 64'd1);
    tick();
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // RAM-side monitor: hold checks while stalled, scoreboard compare on every accept.
  initial begin : monitor
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;
    logic [47:0] e;
    prev_stall = 1'b0;
    prev_addr  = 16'd0;
    prev_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("hold_we", 64'(mem_if.mem_we), 64'd1);
        check("hold_addr", 64'(mem_if.mem_addr), 64'(prev_addr));
        check("hold_data", 64'(mem_if.mem_wdata), 64'(prev_data));
      end
      if (mem_if.mem_we && mem_if.mem_ready) begin
        n_writes++;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_if.mem_addr), 64'(e[47:32]));
          check("wr_data", 64'(mem_if.mem_wdata), 64'(e[31:0]));
        end
      end
      prev_stall = mem_if.mem_we && !mem_if.mem_ready;
      prev_addr  = mem_if.mem_addr;
      prev_data  = mem_if.mem_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    logic [7:0]  b0;
    reset            = 1'b1;
    start            = 1'b0;
    base_addr        = 16'd0;
    row_stride       = 16'd0;
    num_pixels       = 9'd0;
    in_valid         = 4'd0;
    in_row           = '0;
    in_col           = '0;
    in_data          = '0;
    mem_if.mem_ready = 1'b1;
    repeat (3) tick();
    check("rst_we", 64'(mem_if.mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    tick();

    // Aligned lanes, exact latency and done timing.
    start_tile(16'h0100, 16'd4, 9'd1);
    check("t1_busy", 64'(busy), 64'd1);
    exp_q.push_back({16'h0106, 32'h04030201});
    put_lanes(4'hF, 4'd1, 4'd2, 32'h04030201);
    check("t1_lat_early", 64'(mem_if.mem_we), 64'd0);
    tick();
    check("t1_we", 64'(mem_if.mem_we), 64'd1);
    check("t1_addr", 64'(mem_if.mem_addr), 64'h0106);
    tick();
    check("t1_done_early", 64'(done), 64'd0);
    tick();
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_done", 64'(busy), 64'd1);
    tick();
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);

    // Staggered lanes of one pixel.
    start_tile(16'h0200, 16'd8, 9'd1);
    w0 = n_writes;
    exp_q.push_back({exp_addr(16'h0200, 16'd8, 4'd0, 4'd0), 32'hD3D2D1D0});
    put_lanes(4'b0001, 4'd0, 4'd0, 32'h000000D0);
    put_lanes(4'b0010, 4'd0, 4'd0, 32'h0000D100);
    put_lanes(4'b0100, 4'd0, 4'd0, 32'h00D20000);
    put_lanes(4'b1000, 4'd0, 4'd0, 32'hD3000000);
    check("t2_lat_early", 64'(mem_if.mem_we), 64'd0);
    tick();
    check("t2_we", 64'(mem_if.mem_we), 64'd1);
    wait_done("t2_done", 20);
    check("t2_one_write", 64'(n_writes - w0), 64'd1);

    // Backpressure: P1 keeps slot 1, P2 reuses slot 0, so P2 drains before P1.
    mem_if.mem_ready = 1'b0;
    start_tile(16'h0300, 16'd16, 9'd3);
    exp_q.push_back({exp_addr(16'h0300, 16'd16, 4'd1, 4'd1), 32'h13121110});
    exp_q.push_back({exp_addr(16'h0300, 16'd16, 4'd3, 4'd0), 32'h33323130});
    exp_q.push_back({exp_addr(16'h0300, 16'd16, 4'd2, 4'd3), 32'h23222120});
    w0 = n_writes;
    put_lanes(4'hF, 4'd1, 4'd1, 32'h13121110);
    put_lanes(4'hF, 4'd2, 4'd3, 32'h23222120);
    put_lanes(4'hF, 4'd3, 4'd0, 32'h33323130);
    repeat (5) tick();
    check("t3_no_write", 64'(n_writes - w0), 64'd0);
    check("t3_stall_addr", 64'(mem_if.mem_addr), 64'h0311);
    mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t3_b2b", 64'(mem_if.mem_we), 64'd1);
      tick();
    end
    wait_done("t3_done", 20);
    check("t3_writes", 64'(n_writes - w0), 64'd3);

    // Overflow: four partial slots, fifth tag dropped.
    start_tile(16'h0400, 16'd1, 9'd4);
    for (int i = 0; i < 4; i++) begin
      b0 = 8'hA0 + 8'(i);
      put_lanes(4'b0001, 4'd0, 4'(i), {24'd0, b0});
    end
    check("t4_no_ovf", 64'(overflow), 64'd0);
    put_lanes(4'b0001, 4'd0, 4'd4, 32'h000000EE);
    check("t4_ovf", 64'(overflow), 64'd1);
`ifdef REQ_WRITER_PERF_EN
    check("t4_max_slots", 64'(max_slots_used), 64'd4);
`endif
    w0 = n_writes;
    for (int i = 0; i < 4; i++) begin
      b0 = 8'(i);
      exp_q.push_back({exp_addr(16'h0400, 16'd1, 4'd0, 4'(i)),
                       8'h30 + b0, 8'h20 + b0, 8'h10 + b0, 8'hA0 + b0});
      put_lanes(4'b1110, 4'd0, 4'(i), {8'h30 + b0, 8'h20 + b0, 8'h10 + b0, 8'h00});
    end
    wait_done("t4_done", 20);
    check("t4_writes", 64'(n_writes - w0), 64'd4);
    check("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Address wrap modulo 2^16.
    start_tile(16'hFFFE, 16'd1, 9'd1);
    check("t5_ovf_clr", 64'(overflow), 64'd0);
    exp_q.push_back({16'h0001, 32'h44332211});
    put_lanes(4'hF, 4'd0, 4'd3, 32'h44332211);
    tick();
    check("t5_wrap_addr", 64'(mem_if.mem_addr), 64'h0001);
    wait_done("t5_done", 20);

    // Reset mid-tile discards partial slots.
    start_tile(16'h0500, 16'd1, 9'd4);
    put_lanes(4'b0001, 4'd1, 4'd1, 32'h000000AA);
    put_lanes(4'b0001, 4'd2, 4'd2, 32'h000000BB);
    w0 = n_writes;
    reset = 1'b1;
    tick();
    check("t6_rst_we", 64'(mem_if.mem_we), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    check("t6_idle", 64'(busy), 64'd0);
    start_tile(16'h0600, 16'd2, 9'd1);
    put_lanes(4'b1110, 4'd1, 4'd1, 32'h77665500);
    repeat (3) tick();
    check("t6_no_stale", 64'(mem_if.mem_we), 64'd0);
    check("t6_no_write", 64'(n_writes - w0), 64'd0);
    exp_q.push_back({exp_addr(16'h0600, 16'd2, 4'd1, 4'd1), 32'h77665544});
    put_lanes(4'b0001, 4'd1, 4'd1, 32'h00000044);
    wait_done("t6_done", 20);
    check("t6_one_write", 64'(n_writes - w0), 64'd1);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
